// File: rtl/press_gen.sv
// Turns single-cycle request pulses into fixed-length active-low presses with a release gap.
// Optional sticky overflow output enabled by PRESS_GEN_OVF_EN.
module press_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int QDEPTH_W    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                p_in,
  output logic                b_out,
  output logic                busy,
  output logic [QDEPTH_W-1:0] pend_cnt
`ifdef PRESS_GEN_OVF_EN
  ,
  output logic                ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GP  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [QDEPTH_W-1:0] pend_q, pend_d;
  logic                b_out_q, b_out_d;
  logic                busy_q, busy_d;

  logic [QDEPTH_W-1:0] p_ext;
  logic [QDEPTH_W-1:0] one_ext;
  logic [QDEPTH_W:0]   req;
  logic                launch;
  logic                drop;

  always_comb begin
    p_ext      = '0;
    p_ext[0]   = p_in;
    one_ext    = '0;
    one_ext[0] = 1'b1;
    req        = {1'b0, pend_q} + {1'b0, p_ext};
    state_d    = state_q;
    cnt_d      = cnt_q;
    launch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_in) begin
          state_d = PRESS;
          cnt_d   = HLD;
          launch  = 1'b1;
        end
      end
      PRESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = GAP;
          cnt_d   = GP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (req != '0) begin
          state_d = PRESS;
          cnt_d   = HLD;
          launch  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // req's top bit set means the count would exceed saturation
    drop = !launch && req[QDEPTH_W];
    if (launch)
      pend_d = pend_q + p_ext - one_ext;
    else if (drop)
      pend_d = '1;
    else
      pend_d = req[QDEPTH_W-1:0];
    b_out_d = (state_d != PRESS);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      b_out_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
    end
  end

  assign b_out    = b_out_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;

`ifdef PRESS_GEN_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge CLK) begin
    if (!RST) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_press_gen.sv
// Scoreboard bench for press_gen: a reference model queues expected outputs per edge.
// Launch edges are also checked against fixed scenario timings.
module tb_press_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       p_in = 1'b0;
  logic       b_out;
  logic       busy;
  logic [1:0] pend_cnt;
`ifdef PRESS_GEN_OVF_EN
  logic       ovf;
`endif

  press_gen dut (
    .CLK(CLK),
    .RST(RST),
    .p_in(p_in),
    .b_out(b_out),
    .busy(busy),
    .pend_cnt(pend_cnt)
`ifdef PRESS_GEN_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  int m_st = 0;
  int m_cnt = 0;
  int m_pend = 0;
  bit m_ovf = 0;

  typedef struct {
    bit b;
    bit bz;
    int pend;
    bit ov;
  } exp_t;

  exp_t sb[$];
  int   launches[$];
  bit   prev_b = 1'b1;

  task automatic model(input bit rst_n, input bit p);
    int req;
    bit lau;
    lau = 0;
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_pend = 0; m_ovf = 0;
      return;
    end
    req = m_pend + int'(p);
    if (m_st == 0) begin
      if (p) begin m_st = 1; m_cnt = 3; lau = 1; end
    end else if (m_st == 1) begin
      if (m_cnt > 0) m_cnt--;
      else begin m_st = 2; m_cnt = 1; end
    end else begin
      if (m_cnt > 0) m_cnt--;
      else if (req > 0) begin m_st = 1; m_cnt = 3; lau = 1; end
      else m_st = 0;
    end
    if (lau) m_pend = req - 1;
    else if (req > 3) begin m_pend = 3; m_ovf = 1; end
    else m_pend = req;
  endtask

  task automatic step(input int e, input bit rst_n, input bit p);
    exp_t x;
    RST  = rst_n;
    p_in = p;
    model(rst_n, p);
    x.b = (m_st != 1);
    x.bz = (m_st != 0);
    x.pend = m_pend;
    x.ov = m_ovf;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    chk($sformatf("b_out@%0d", e), 32'(b_out), 32'(x.b));
    chk($sformatf("busy@%0d", e), 32'(busy), 32'(x.bz));
    chk($sformatf("pend@%0d", e), 32'(pend_cnt), 32'(x.pend));
`ifdef PRESS_GEN_OVF_EN
    chk($sformatf("ovf@%0d", e), 32'(ovf), 32'(x.ov));
`endif
    if (prev_b === 1'b1 && b_out === 1'b0) launches.push_back(e);
    prev_b = b_out;
  endtask

  task automatic scen(input string nm, input logic [63:0] pm,
                      input logic [63:0] rm, input int len,
                      input int expl[$]);
    launches.delete();
    for (int e = 0; e < len; e++)
      step(e, !rm[e], pm[e]);
    chk({nm, ".nlaunch"}, 32'(launches.size()), 32'(expl.size()));
    for (int i = 0; i < expl.size() && i < launches.size(); i++)
      chk($sformatf("%s.launch%0d", nm, i), 32'(launches[i]), 32'(expl[i]));
  endtask

  localparam logic [63:0] R2 = 64'h3;

  initial begin
    int none[$];
    none = {};
    // reset with p_in held high
    scen("rst", 64'h3, R2, 4, none);
    chk("rst.b_out", 32'(b_out), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pend", 32'(pend_cnt), 32'd0);
`ifdef PRESS_GEN_OVF_EN
    chk("rst.ovf", 32'(ovf), 32'd0);
`endif

    scen("single", 64'd1 << 10, R2, 20, '{10});

    scen("queued", (64'd1 << 10) | (64'd1 << 12), R2, 26, '{10, 16});
    chk("queued.idle", 32'(busy), 32'd0);

    scen("sat", (64'h1F << 10), R2, 40, '{10, 16, 22, 28});
`ifdef PRESS_GEN_OVF_EN
    chk("sat.ovf", 32'(ovf), 32'd1);
`endif

    scen("simul", (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 16), R2, 32,
         '{10, 16, 22});

    scen("midrst", (64'd3 << 10) | (64'd1 << 20), R2 | (64'd1 << 12), 30,
         '{10, 20});
    chk("midrst.end_b", 32'(b_out), 32'd1);
    chk("midrst.end_pend", 32'(pend_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/press_gen.md
Name: press_gen

Overview:
Pulse-to-press generator: converts single-cycle request pulses into active-low, button-style level presses of fixed length, separated by a minimum release gap. It is the inverse of the button edge shaper. Game/login logic uses it to emulate button activity toward downstream press-consuming blocks and bench models. Requests that arrive while a press is in progress are counted and replayed in order, up to a saturating limit.

Parameters:
HOLD_CYCLES, 4, number of cycles b_out is held low per press (>=1)
GAP_CYCLES, 2, minimum number of cycles b_out is held high between presses (>=1)
CNT_W, 8, width of the hold/gap down-counter; must represent max(HOLD_CYCLES, GAP_CYCLES)
QDEPTH_W, 2, width of the pending-request counter; the counter saturates at 2^QDEPTH_W-1

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-low
p_in  input  1  request pulse, active-high; every cycle it is high counts as one request
b_out  output  1  emulated button, active-low (1 = released)
busy  output  1  high when state is not IDLE
pend_cnt  output  QDEPTH_W  number of queued requests not yet launched

Behaviour:
- Reset is decided as: reset RST, synchronous, active-low; clock CLK.
- While RST=0 at a rising edge, the following values apply after that edge: state=IDLE, b_out=1, busy=0, pend_cnt=0, counter=0. p_in is ignored.
- All outputs are registered. There are no combinational paths from p_in to any output.
- FSM states: IDLE, PRESS, GAP.
- Request accounting at each edge: req = pend_cnt + p_in.
  - If a press launches on this edge: pend_cnt <= req-1.
  - Otherwise: pend_cnt <= min(req, 2^QDEPTH_W-1). A request above saturation is dropped.
- IDLE (b_out=1, busy=0):
  - If p_in=1 at edge k: go to PRESS at edge k, load counter=HOLD_CYCLES-1. b_out=0 is visible after edge k (1-edge latency).
  - pend_cnt is always 0 in IDLE.
- PRESS (b_out=0, busy=1):
  - While counter>0: decrement each edge.
  - When counter=0: go to GAP, load counter=GAP_CYCLES-1, b_out<=1.
  - b_out therefore stays low for exactly HOLD_CYCLES cycles.
- GAP (b_out=1, busy=1):
  - While counter>0: decrement each edge.
  - When counter=0 and req>0: launch a press. Go to PRESS, b_out<=0, load HOLD_CYCLES-1, pend_cnt<=req-1.
  - When counter=0 and req=0: go to IDLE, busy<=0.
- Back-to-back presses: launch-to-launch period is HOLD_CYCLES+GAP_CYCLES edges. The gap is never shortened.
- Simultaneous p_in and launch at GAP exit: the launch and the new request cancel, so pend_cnt is unchanged.
- Reset mid-press or mid-gap: the next edge with RST=0 forces IDLE, b_out=1, and clears the queue. No partial press is resumed.
- Illegal state encoding: go to IDLE with b_out=1.

Optional Feature:
Macro PRESS_GEN_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf is a sticky flag set on any edge where a request is dropped by saturation. It is cleared only by reset. Reset value is 0.
- Undefined: the ovf port and its logic are absent, and dropped requests are silent. All other behaviour is identical.

Test Plan:
All scenarios use defaults: HOLD=4, GAP=2, QDEPTH_W=2.
1. Reset: hold RST=0 for 2 edges, with p_in=1 throughout -> b_out=1, busy=0, pend_cnt=0 (ovf=0).
2. Single pulse: p_in=1 at edge 10 only -> b_out=0 after edges 10-13, b_out=1 after edge 14; busy=1 after edges 10-15, busy=0 after edge 16.
3. Queued request: pulses at edges 10 and 12 -> pend_cnt=1 after edge 12; second press b_out=0 after edges 16-19, pend_cnt=0 after edge 16; IDLE after edge 22.
4. Saturation: pulse at edge 10, then pulses at edges 11, 12, 13, 14 -> pend_cnt=1,2,3,3; ovf=1 after edge 14 if the macro is defined; exactly 4 presses total, starting at edges 10, 16, 22, 28.
5. Simultaneous launch and request: pulses at edges 10 and 12, plus p_in=1 at edge 16 -> the press launches at 16 with pend_cnt staying 1; a third press starts at edge 22.
6. Reset mid-press: pulse at edge 10, pulse at 11, RST=0 at edge 12 -> b_out=1, pend_cnt=0 after edge 12; a subsequent pulse at edge 20 gives a normal 4-cycle press from edge 20.
